// File: rtl/dm_mem_stage_pkg.sv
// Shared constants and helpers for the MEM-stage data memory.
// Size encodings, lane masks and the store-data replication rule.
// Pure definitions: no latency, no backpressure.
package dm_mem_stage_pkg;

   localparam logic [1:0] SIZE_W = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_B = 2'b10;

   localparam logic [3:0] MASK_WORD = 4'b1111;
   localparam logic [3:0] MASK_LO   = 4'b0011;
   localparam logic [3:0] MASK_HI   = 4'b1100;

   // Store data is right-justified; replicate it so every lane sees its bytes.
   function automatic logic [31:0] replicateData(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SIZE_H:  replicateData = {2{wdata[15:0]}};
         SIZE_B:  replicateData = {4{wdata[7:0]}};
         default: replicateData = wdata;
      endcase
   endfunction

endpackage

// File: rtl/dm_mem_stage_lane_dec.sv
// Byte-lane decoder: access size and low address bits to lane mask and misalign flag.
// Combinational, zero latency.
// No flow control; reserved size yields an empty mask.
module dm_lane_dec
   import dm_mem_stage_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addrLo,
   output logic [3:0] mask,
   output logic       misalign
);

   always_comb begin
      mask     = 4'b0000;
      misalign = 1'b0;
      case (size)
         SIZE_W: begin
            mask     = MASK_WORD;
            misalign = |addrLo;
         end
         SIZE_H: begin
            mask     = addrLo[1] ? MASK_HI : MASK_LO;
            misalign = addrLo[0];
         end
         SIZE_B: mask = 4'b0001 << addrLo;
         default: ;
      endcase
   end

endmodule

// File: rtl/dm_mem_stage.sv
// MEM stage: byte-lane data memory with MEM/WB registers for the raw load word and lane mask.
// Loads return one cycle later; stores commit at the edge.
// hold freezes memory and outputs; no other backpressure.
module dm_mem_stage
   import dm_mem_stage_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic        mem_we,
   input  logic        mem_re,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [3:0]  BRE,
   output logic [31:0] DR,
   output logic        load_valid,
   output logic        addr_err
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

   logic [31:0]      mem [DEPTH_WORDS];
   logic [3:0]       laneMask;
   logic             misalign;
   logic             illegal;
   logic             doStore;
   logic             doLoad;
   logic [IDX_W-1:0] wordIdx;
   logic [31:0]      storeData;

   dm_lane_dec uLaneDec (
      .size     (size),
      .addrLo   (addr[1:0]),
      .mask     (laneMask),
      .misalign (misalign)
   );

   // Upper address bits only feed the range check, so out-of-range never aliases.
   assign wordIdx   = addr[IDX_W+1:2];
   assign illegal   = misalign || (size == 2'b11) || (addr >= BYTE_LIMIT);
   assign doStore   = !hold && mem_we && !illegal;
   assign doLoad    = !hold && mem_re && !mem_we && !illegal;
   assign storeData = replicateData(size, wdata);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < DEPTH_WORDS; w++) mem[w] <= '0;
      end else if (doStore) begin
         for (int i = 0; i < 4; i++)
            if (laneMask[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
   end

   // Read samples the pre-edge word, so a store one cycle earlier is already visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         BRE        <= '0;
         DR         <= '0;
         load_valid <= 1'b0;
         addr_err   <= 1'b0;
      end else if (!hold) begin
         BRE        <= doLoad ? laneMask : 4'b0000;
         DR         <= doLoad ? mem[wordIdx] : 32'h0;
         load_valid <= doLoad;
         addr_err   <= (mem_we || mem_re) && illegal;
      end
   end

endmodule

// File: tb/tb_dm_mem_stage.sv
// Directed bench for dm_mem_stage: table of single-cycle accesses plus hold and reset sequences.
module tb_dm_mem_stage;

   logic        clk;
   logic        reset;
   logic        hold;
   logic        memWe;
   logic        memRe;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  bre;
   logic [31:0] dr;
   logic        loadValid;
   logic        addrErr;

   int nChecks = 0;
   int nFail   = 0;

   typedef struct {
      string       name;
      logic        we;
      logic        re;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  eBre;
      logic [31:0] eDr;
      logic        eLv;
      logic        eErr;
   } vec_t;

   vec_t vecs[$];

   dm_mem_stage #(.DEPTH_WORDS(1024)) dut (
      .clk        (clk),
      .reset      (reset),
      .hold       (hold),
      .mem_we     (memWe),
      .mem_re     (memRe),
      .size       (size),
      .addr       (addr),
      .wdata      (wdata),
      .BRE        (bre),
      .DR         (dr),
      .load_valid (loadValid),
      .addr_err   (addrErr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkAll(input string name, input logic [3:0] eBre, input logic [31:0] eDr,
                           input logic eLv, input logic eErr);
      check({name, ".BRE"}, 32'(bre), 32'(eBre));
      check({name, ".DR"}, dr, eDr);
      check({name, ".load_valid"}, 32'(loadValid), 32'(eLv));
      check({name, ".addr_err"}, 32'(addrErr), 32'(eErr));
   endtask

   task automatic drive(input logic h, input logic we, input logic re, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
      hold  = h;
      memWe = we;
      memRe = re;
      size  = sz;
      addr  = a;
      wdata = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input string name, input logic we, input logic re, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] eBre,
                         input logic [31:0] eDr, input logic eLv, input logic eErr);
      vec_t v;
      v.name = name; v.we = we; v.re = re; v.sz = sz; v.a = a; v.wd = wd;
      v.eBre = eBre; v.eDr = eDr; v.eLv = eLv; v.eErr = eErr;
      vecs.push_back(v);
   endtask

   initial begin
      //      name          we  re  size   addr        wdata         BRE      DR            lv  err
      addVec("sw_10",       1,  0,  2'b00, 32'h10,     32'h11223344, 4'b0000, 32'h0,        0,  0);
      addVec("lw_10",       0,  1,  2'b00, 32'h10,     32'h0,        4'b1111, 32'h11223344, 1,  0);
      addVec("sb_13",       1,  0,  2'b10, 32'h13,     32'h000000AB, 4'b0000, 32'h0,        0,  0);
      addVec("lb_13",       0,  1,  2'b10, 32'h13,     32'h0,        4'b1000, 32'hAB223344, 1,  0);
      addVec("sh_12",       1,  0,  2'b01, 32'h12,     32'h0000BEEF, 4'b0000, 32'h0,        0,  0);
      addVec("lh_12",       0,  1,  2'b01, 32'h12,     32'h0,        4'b1100, 32'hBEEF3344, 1,  0);
      addVec("lw_mis_12",   0,  1,  2'b00, 32'h12,     32'h0,        4'b0000, 32'h0,        0,  1);
      addVec("idle",        0,  0,  2'b00, 32'h12,     32'h0,        4'b0000, 32'h0,        0,  0);
      addVec("sh_mis_11",   1,  0,  2'b01, 32'h11,     32'h00001234, 4'b0000, 32'h0,        0,  1);
      addVec("lw_10_kept",  0,  1,  2'b00, 32'h10,     32'h0,        4'b1111, 32'hBEEF3344, 1,  0);
      addVec("sw_oor_1000", 1,  0,  2'b00, 32'h1000,   32'hDEADBEEF, 4'b0000, 32'h0,        0,  1);
      addVec("lw_0_noalias",0,  1,  2'b00, 32'h0,      32'h0,        4'b1111, 32'h0,        1,  0);
      addVec("sb_01",       1,  0,  2'b10, 32'h1,      32'hFFFFFF5A, 4'b0000, 32'h0,        0,  0);
      addVec("lb_01",       0,  1,  2'b10, 32'h1,      32'h0,        4'b0010, 32'h00005A00, 1,  0);
      addVec("ld_size11",   0,  1,  2'b11, 32'h10,     32'h0,        4'b0000, 32'h0,        0,  1);
      addVec("we_re_both",  1,  1,  2'b00, 32'h20,     32'h01020304, 4'b0000, 32'h0,        0,  0);
      addVec("lw_20",       0,  1,  2'b00, 32'h20,     32'h0,        4'b1111, 32'h01020304, 1,  0);
      addVec("sb_fff",      1,  0,  2'b10, 32'hFFF,    32'h00000077, 4'b0000, 32'h0,        0,  0);
      addVec("lw_ffc",      0,  1,  2'b00, 32'hFFC,    32'h0,        4'b1111, 32'h77000000, 1,  0);
      addVec("lb_oor",      0,  1,  2'b10, 32'h1003,   32'h0,        4'b0000, 32'h0,        0,  1);
      addVec("sh_16",       1,  0,  2'b01, 32'h16,     32'h1234CAFE, 4'b0000, 32'h0,        0,  0);
      addVec("lhu_14",      0,  1,  2'b01, 32'h14,     32'h0,        4'b0011, 32'hCAFE0000, 1,  0);

      reset = 1'b0;
      hold  = 1'b0;
      memWe = 1'b0;
      memRe = 1'b0;
      size  = 2'b00;
      addr  = 32'h0;
      wdata = 32'h0;
      repeat (2) @(posedge clk);
      #3;
      checkAll("reset_state", 4'b0000, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(1'b0, vecs[i].we, vecs[i].re, vecs[i].sz, vecs[i].a, vecs[i].wd);
         checkAll(vecs[i].name, vecs[i].eBre, vecs[i].eDr, vecs[i].eLv, vecs[i].eErr);
      end

      // Hold: outputs frozen on a valid load, store under hold is dropped.
      drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h10, 32'h0);
      checkAll("pre_hold_lw", 4'b1111, 32'hBEEF3344, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h10, 32'hFFFFFFFF);
      checkAll("hold_sw_1", 4'b1111, 32'hBEEF3344, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h12, 32'h0);
      checkAll("hold_bad_ld", 4'b1111, 32'hBEEF3344, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      checkAll("hold_release", 4'b0000, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h10, 32'h0);
      checkAll("post_hold_lw", 4'b1111, 32'hBEEF3344, 1'b1, 1'b0);

      // Error held across hold, then cleared the cycle after release.
      drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h2, 32'h0);
      checkAll("err_set", 4'b0000, 32'h0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      checkAll("err_frozen", 4'b0000, 32'h0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      checkAll("err_clear", 4'b0000, 32'h0, 1'b0, 1'b0);

      // Mid-run reset clears outputs immediately and wipes memory; no write while low.
      drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h20, 32'h0);
      checkAll("pre_reset_lw", 4'b1111, 32'h01020304, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checkAll("reset_async", 4'b0000, 32'h0, 1'b0, 1'b0);
      hold  = 1'b0;
      memWe = 1'b1;
      memRe = 1'b0;
      size  = 2'b00;
      addr  = 32'h0;
      wdata = 32'hA5A5A5A5;
      @(posedge clk);
      #3;
      checkAll("reset_low_edge", 4'b0000, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      memWe = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
      checkAll("post_reset_lw_0", 4'b1111, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h10, 32'h0);
      checkAll("post_reset_lw_10", 4'b1111, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h20, 32'h0);
      checkAll("post_reset_lw_20", 4'b1111, 32'h0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
